bip_control: RTL and testbench



---
 rtl/bip_control_if.sv | 33 +++
 rtl/bip_control.sv | 152 +++++++++++++++
 tb/tb_bip_control.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_if.sv
// ----------------------------------------------------------------------------
// bip_control_if
// Bundles the fetch/decode stage's bus signals: program memory address and
// instruction, the start/halted handshake and the datapath decode strobes.
//   master : the controller (drives addr, operand, strobes, halted)
//   slave  : memory/datapath side (drives start, instruction)
// ----------------------------------------------------------------------------
interface bip_control_if #(
    parameter int ADDR_LENGTH  = 11,
    parameter int INSTR_LENGTH = 16
);
    logic                    start;
    logic [INSTR_LENGTH-1:0] instruction;
    logic [ADDR_LENGTH-1:0]  addr;
    logic [ADDR_LENGTH-1:0]  operand;
    logic [1:0]              sel_a;
    logic                    sel_b;
    logic                    wr_acc;
    logic                    alu_op;
    logic                    wr_ram;
    logic                    rd_ram;
    logic                    halted;

    modport master (
        input  start, instruction,
        output addr, operand, sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram, halted
    );

    modport slave (
        output start, instruction,
        input  addr, operand, sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram, halted
    );
endinterface

// File: rtl/bip_control.sv
// ----------------------------------------------------------------------------
// bip_control
// Fetch/decode control stage in front of a program memory with 1-cycle
// synchronous read latency. Runs a 2-cycle FETCH/EXEC loop, holds the PC
// (driven straight out as addr) and decodes the returned instruction into
// single-cycle datapath strobes.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   bus.start    level; leaves IDLE when high
//   bus.instruction  program word, valid in EXEC
//   bus.addr     program counter
//   bus.operand  instruction low field (EXEC only, else 0)
//   bus.sel_a/sel_b/wr_acc/alu_op/wr_ram/rd_ram  decode strobes (EXEC only)
//   bus.halted   registered, high while in HALTED
//   cycle_count  (CYCLE_COUNTER_EN only) saturating count of FETCH/EXEC cycles
//
// Optional feature macro: CYCLE_COUNTER_EN
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | addr=pc presented, memory reads it at the next edge
// S_EXEC   | instruction valid, strobes asserted, pc advances (unless HLT)
// S_HALTED | HLT executed; only reset leaves
// ----------------------------------------------------------------------------
module bip_control #(
    parameter int ADDR_LENGTH   = 11,
    parameter int OPCODE_LENGTH = 5,
    parameter int INSTR_LENGTH  = 16
) (
    input  logic          clk,
    input  logic          reset,
    bip_control_if.master bus
`ifdef CYCLE_COUNTER_EN
    ,
    output logic [31:0]   cycle_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_HLT  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OP_STO  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OP_LD   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OP_LDI  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADDI = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUBI = OPCODE_LENGTH'(7);

    state_t                   state_q, state_d;
    logic [ADDR_LENGTH-1:0]   pc_q, pc_d;
    logic                     halted_q;
    logic [OPCODE_LENGTH-1:0] opcode;

    assign opcode     = bus.instruction[INSTR_LENGTH-1 -: OPCODE_LENGTH];
    assign bus.addr   = pc_q;
    assign bus.halted = halted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        bus.operand = '0;
        bus.sel_a   = 2'd0;
        bus.sel_b   = 1'b0;
        bus.wr_acc  = 1'b0;
        bus.alu_op  = 1'b0;
        bus.wr_ram  = 1'b0;
        bus.rd_ram  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                bus.operand = bus.instruction[ADDR_LENGTH-1:0];
                case (opcode)
                    OP_STO: bus.wr_ram = 1'b1;
                    OP_LD: begin
                        bus.rd_ram = 1'b1;
                        bus.wr_acc = 1'b1;
                    end
                    OP_LDI: begin
                        bus.sel_a  = 2'd1;
                        bus.wr_acc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bus.rd_ram = 1'b1;
                        bus.alu_op = (opcode == OP_SUB);
                        bus.sel_a  = 2'd2;
                        bus.wr_acc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        bus.sel_b  = 1'b1;
                        bus.alu_op = (opcode == OP_SUBI);
                        bus.sel_a  = 2'd2;
                        bus.wr_acc = 1'b1;
                    end
                    default: ;
                endcase
                // HLT freezes pc so addr keeps pointing at the HLT word.
                if (opcode == OP_HLT) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + ADDR_LENGTH'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if ((state_q == S_FETCH || state_q == S_EXEC) && cycle_cnt_q != '1) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_count = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_bip_control.sv
module tb_bip_control;
    localparam int AL = 11;
    localparam int OL = 5;
    localparam int IL = 16;
    localparam int DEPTH = 2 ** AL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bip_control_if #(.ADDR_LENGTH(AL), .INSTR_LENGTH(IL)) bus ();

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
`endif

    bip_control #(.ADDR_LENGTH(AL), .OPCODE_LENGTH(OL), .INSTR_LENGTH(IL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CYCLE_COUNTER_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    // Program memory: synchronous read, 1-cycle latency.
    logic [IL-1:0] mem [0:DEPTH-1];
    always @(posedge clk) bus.instruction <= mem[bus.addr];

    int checks = 0;
    int errors = 0;

    // Expected strobe bundle {sel_a, sel_b, wr_acc, alu_op, wr_ram, rd_ram}.
    typedef struct {
        logic [OL-1:0] op;
        logic [AL-1:0] operand;
        logic [6:0]    exp;
    } vec_t;

    vec_t       tbl [10];
    logic [6:0] exp_by_op [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.sel_a, bus.sel_b, bus.wr_acc, bus.alu_op, bus.wr_ram, bus.rd_ram};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [IL-1:0] ins(input int op, input int opd);
        logic [OL-1:0] o;
        logic [AL-1:0] d;
        o = OL'(op);
        d = AL'(opd);
        return {o, d};
    endfunction

    // Instruction-level model: pc walks the program, each instruction takes a
    // fetch cycle then an exec cycle, HLT stops with pc parked on it.
    task automatic run(input int max_instr, input bit expect_halt, input bit rand_start);
        int  pc;
        int  n;
        bit  hit;
        logic [IL-1:0] w;
        pc  = 0;
        n   = 0;
        hit = 1'b0;
        do_reset();
        bus.start = 1'b1;
        step();
        while (n < max_instr && !hit) begin
            bus.start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("fetch_addr", 32'(bus.addr), 32'(pc));
            chk("fetch_strobes", 32'(strobes()), 32'd0);
            chk("fetch_operand", 32'(bus.operand), 32'd0);
            chk("fetch_halted", 32'(bus.halted), 32'd0);
            step();
            w = mem[pc];
            chk("exec_strobes", 32'(strobes()), 32'(exp_by_op[w[IL-1 -: OL]]));
            chk("exec_operand", 32'(bus.operand), 32'(w[AL-1:0]));
            chk("exec_addr", 32'(bus.addr), 32'(pc));
            n++;
            step();
            if (w[IL-1 -: OL] == 0) hit = 1'b1;
            else pc = (pc + 1) % DEPTH;
        end
        chk("halt_reached", 32'(hit), 32'(expect_halt));
        if (hit) begin
            for (int i = 0; i < 3; i++) begin
                bus.start = 1'b1;
                chk("halted_flag", 32'(bus.halted), 32'd1);
                chk("halted_addr", 32'(bus.addr), 32'(pc));
                chk("halted_strobes", 32'(strobes()), 32'd0);
`ifdef CYCLE_COUNTER_EN
                chk("cycle_count", cycle_count, 32'(2 * n));
`endif
                step();
            end
        end else begin
            chk("no_halt_flag", 32'(bus.halted), 32'd0);
            chk("wrap_addr", 32'(bus.addr), 32'(pc));
        end
        bus.start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        clear_mem();

        tbl[0] = '{5'd1,  11'h010, 7'b00_0_0_0_1_0}; // STO
        tbl[1] = '{5'd2,  11'h123, 7'b00_0_1_0_0_1}; // LD
        tbl[2] = '{5'd3,  11'h005, 7'b01_0_1_0_0_0}; // LDI
        tbl[3] = '{5'd4,  11'h2AA, 7'b10_0_1_0_0_1}; // ADD
        tbl[4] = '{5'd31, 11'h555, 7'b00_0_0_0_0_0}; // undefined at addr 4
        tbl[5] = '{5'd5,  11'h003, 7'b10_1_1_0_0_0}; // ADDI
        tbl[6] = '{5'd6,  11'h7FF, 7'b10_0_1_1_0_1}; // SUB 0x7FF
        tbl[7] = '{5'd7,  11'h001, 7'b10_1_1_1_0_0}; // SUBI
        tbl[8] = '{5'd8,  11'h0F0, 7'b00_0_0_0_0_0}; // undefined
        tbl[9] = '{5'd0,  11'h000, 7'b00_0_0_0_0_0}; // HLT
        for (int i = 0; i < 32; i++) exp_by_op[i] = 7'd0;
        for (int i = 0; i < 10; i++) exp_by_op[tbl[i].op] = tbl[i].exp;

        // Idle after reset with start low.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle_addr", 32'(bus.addr), 32'd0);
            chk("idle_strobes", 32'(strobes()), 32'd0);
            chk("idle_halted", 32'(bus.halted), 32'd0);
`ifdef CYCLE_COUNTER_EN
            chk("idle_count", cycle_count, 32'd0);
`endif
            step();
        end

        // Directed 4-instruction program.
        mem[0] = ins(3, 5);
        mem[1] = ins(5, 3);
        mem[2] = ins(1, 11'h010);
        mem[3] = ins(0, 0);
        run(10, 1'b1, 1'b0);

        // Table program: one word per vector, applied in order.
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = {tbl[i].op, tbl[i].operand};
        run(20, 1'b1, 1'b1);

        // Reset in the EXEC cycle of ADD cancels the strobes.
        clear_mem();
        mem[0] = ins(4, 11'h044);
        do_reset();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("add_exec_strobes", 32'(strobes()), 32'(7'b10_0_1_0_0_1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_operand", 32'(bus.operand), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
`ifdef CYCLE_COUNTER_EN
        chk("rst_count", cycle_count, 32'd0);
`endif
        step();
        chk("rst_stays_idle", 32'(bus.addr), 32'd0);
        chk("rst_idle_strobes", 32'(strobes()), 32'd0);

        // Random programs ending in HLT.
        for (int p = 0; p < 15; p++) begin
            int len;
            clear_mem();
            len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++)
                mem[i] = ins(int'($urandom_range(1, 31)), int'($urandom_range(0, DEPTH - 1)));
            run(len + 1, 1'b1, 1'b1);
        end

        // PC wrap: all LDI 0, run past the top of memory.
        for (int i = 0; i < DEPTH; i++) mem[i] = ins(3, 0);
        run(DEPTH + 2, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
